// File: rtl/power_toggle_monitor.sv
// -----------------------------------------------------------------------------
// power_toggle_monitor
//
// Activity stage placed downstream of a combinational power sub-circuit.
// It watches the primary inputs and the output of the sub-circuit, counts how
// often each of them toggles over a fixed window of valid samples, and then
// streams one count per signal to the power-estimation collector.
//
// Operation:
//   IDLE   : waits for start. start clears every toggle counter and the
//            window counter. A sample_en in the same cycle is dropped.
//   PRIME  : the first valid sample only seeds the previous-sample register,
//            so that the first counted sample has a reference to compare to.
//   COUNT  : every valid sample adds (sig_in ^ prev) into the per-signal
//            counters (saturating). After 2**WIN_LOG2 counted samples the
//            block moves to REPORT.
//   REPORT : one beat per signal, index 0 first. A beat is held stable until
//            it is accepted. Accepting the last beat returns to IDLE.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a measurement (only honoured in IDLE)
//   sample_en  in   sig_in carries a valid vector this cycle
//   sig_in     in   NUM_SIG monitored signals, bit k = signal k
//   busy       out  high in every state other than IDLE
//   rpt_valid  out  report beat valid
//   rpt_ready  in   collector accepts the current beat
//   rpt_idx    out  signal index of the current beat
//   rpt_count  out  toggle count of signal rpt_idx
//   rpt_last   out  current beat carries index NUM_SIG-1
//
// All outputs come straight from flops. Their next values are derived from
// the next-state logic, so the first beat is valid on the cycle right after
// the final counted sample has been clocked in.
// -----------------------------------------------------------------------------
module power_toggle_monitor #(
  parameter int NUM_SIG  = 5,
  parameter int CNT_W    = 16,
  parameter int WIN_LOG2 = 8,
  localparam int IDX_W   = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sample_en,
  input  logic [NUM_SIG-1:0] sig_in,
  output logic               busy,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [CNT_W-1:0]   rpt_count,
  output logic               rpt_last
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRIME  = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  // The window counter has one spare bit so the full window length is
  // representable after the final sample.
  localparam int              WIN_W    = WIN_LOG2 + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((2 ** WIN_LOG2) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SIG - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // State registers
  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r [NUM_SIG];
  logic [NUM_SIG-1:0] prev_r;
  logic [WIN_W-1:0]   win_r;
  logic [IDX_W-1:0]   idx_r;

  // Output registers
  logic               busy_r;
  logic               rpt_valid_r;
  logic [IDX_W-1:0]   rpt_idx_r;
  logic [CNT_W-1:0]   rpt_count_r;
  logic               rpt_last_r;

  // Next-state values
  logic [1:0]         state_s;
  logic [CNT_W-1:0]   cnt_s [NUM_SIG];
  logic [NUM_SIG-1:0] prev_s;
  logic [WIN_W-1:0]   win_s;
  logic [IDX_W-1:0]   idx_s;
  logic               hs_s;

  // Next output values
  logic               busy_s;
  logic               rpt_valid_s;
  logic [IDX_W-1:0]   rpt_idx_s;
  logic [CNT_W-1:0]   rpt_count_s;
  logic               rpt_last_s;

  assign hs_s = rpt_valid_r & rpt_ready;

  // Next-state logic: FSM transitions, toggle accumulation, beat sequencing
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    prev_s  = prev_r;
    win_s   = win_r;
    idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        // start has priority; any sample offered alongside it is dropped
        if (start) begin
          state_s = ST_PRIME;
          for (int k = 0; k < NUM_SIG; k++) begin
            cnt_s[k] = {CNT_W{1'b0}};
          end
          win_s = {WIN_W{1'b0}};
          idx_s = {IDX_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRIME: begin
        // reference sample only, nothing is counted
        if (sample_en) begin
          prev_s  = sig_in;
          state_s = ST_COUNT;
        end else begin
          state_s = ST_PRIME;
        end
      end
      ST_COUNT: begin
        if (sample_en) begin
          for (int k = 0; k < NUM_SIG; k++) begin
            // saturate rather than wrap so a busy signal never reads as quiet
            if ((sig_in[k] ^ prev_r[k]) && (cnt_r[k] != CNT_MAX)) begin
              cnt_s[k] = cnt_r[k] + CNT_W'(1);
            end else begin
              cnt_s[k] = cnt_r[k];
            end
          end
          prev_s = sig_in;
          win_s  = win_r + WIN_W'(1);
          if (win_r == WIN_LAST) begin
            state_s = ST_REPORT;
            idx_s   = {IDX_W{1'b0}};
          end else begin
            state_s = ST_COUNT;
          end
        end else begin
          state_s = ST_COUNT;
        end
      end
      ST_REPORT: begin
        if (hs_s) begin
          if (idx_r == IDX_LAST) begin
            state_s = ST_IDLE;
            idx_s   = {IDX_W{1'b0}};
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_s = ST_REPORT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next output values, derived from the next state so outputs are registered
  // yet line up with the state they describe
  always_comb begin
    busy_s      = (state_s != ST_IDLE);
    rpt_valid_s = 1'b0;
    rpt_idx_s   = {IDX_W{1'b0}};
    rpt_count_s = {CNT_W{1'b0}};
    rpt_last_s  = 1'b0;
    if (state_s == ST_REPORT) begin
      rpt_valid_s = 1'b1;
      rpt_idx_s   = idx_s;
      rpt_count_s = cnt_s[idx_s];
      rpt_last_s  = (idx_s == IDX_LAST);
    end else begin
      rpt_valid_s = 1'b0;
    end
  end

  // Core state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      for (int k = 0; k < NUM_SIG; k++) begin
        cnt_r[k] <= {CNT_W{1'b0}};
      end
      prev_r <= {NUM_SIG{1'b0}};
      win_r  <= {WIN_W{1'b0}};
      idx_r  <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      prev_r  <= prev_s;
      win_r   <= win_s;
      idx_r   <= idx_s;
    end
  end

  // Output registers; reset drops rpt_valid asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      rpt_valid_r <= 1'b0;
      rpt_idx_r   <= {IDX_W{1'b0}};
      rpt_count_r <= {CNT_W{1'b0}};
      rpt_last_r  <= 1'b0;
    end else begin
      busy_r      <= busy_s;
      rpt_valid_r <= rpt_valid_s;
      rpt_idx_r   <= rpt_idx_s;
      rpt_count_r <= rpt_count_s;
      rpt_last_r  <= rpt_last_s;
    end
  end

  assign busy      = busy_r;
  assign rpt_valid = rpt_valid_r;
  assign rpt_idx   = rpt_idx_r;
  assign rpt_count = rpt_count_r;
  assign rpt_last  = rpt_last_r;

endmodule
